// File: rtl/seg_pkg.sv
// Seven-segment scan shared constants.
// Glyph patterns are active-low, bit6 = g ... bit0 = a.
package seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b100_0000;
    localparam logic [6:0] GLYPH_1 = 7'b111_1001;
    localparam logic [6:0] GLYPH_2 = 7'b010_0100;
    localparam logic [6:0] GLYPH_3 = 7'b011_0000;
    localparam logic [6:0] GLYPH_4 = 7'b001_1001;
    localparam logic [6:0] GLYPH_5 = 7'b001_0010;
    localparam logic [6:0] GLYPH_6 = 7'b000_0010;
    localparam logic [6:0] GLYPH_7 = 7'b111_1000;
    localparam logic [6:0] GLYPH_8 = 7'b000_0000;
    localparam logic [6:0] GLYPH_9 = 7'b001_0000;
    localparam logic [6:0] GLYPH_A = 7'b000_1000;
    localparam logic [6:0] GLYPH_B = 7'b000_0011;
    localparam logic [6:0] GLYPH_C = 7'b100_0110;
    localparam logic [6:0] GLYPH_D = 7'b010_0001;
    localparam logic [6:0] GLYPH_E = 7'b000_0110;
    localparam logic [6:0] GLYPH_F = 7'b000_1110;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    // Widest anode vector; sliced down to DIGITS by the user.
    localparam logic [7:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/seg_glyph.sv
// Combinational nibble-to-glyph lookup.
// valid drops for A-F codes unless hex_mode is set.
module seg_glyph
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [6:0] pattern,
    output logic       valid
);

    always_comb begin
        pattern = GLYPH_0;
        unique case (code)
            4'h0: pattern = GLYPH_0;
            4'h1: pattern = GLYPH_1;
            4'h2: pattern = GLYPH_2;
            4'h3: pattern = GLYPH_3;
            4'h4: pattern = GLYPH_4;
            4'h5: pattern = GLYPH_5;
            4'h6: pattern = GLYPH_6;
            4'h7: pattern = GLYPH_7;
            4'h8: pattern = GLYPH_8;
            4'h9: pattern = GLYPH_9;
            4'hA: pattern = GLYPH_A;
            4'hB: pattern = GLYPH_B;
            4'hC: pattern = GLYPH_C;
            4'hD: pattern = GLYPH_D;
            4'hE: pattern = GLYPH_E;
            4'hF: pattern = GLYPH_F;
        endcase
        valid = hex_mode || (code < 4'hA);
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with frame shadowing,
// per-digit blanking/blink and an anode ghost guard.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  hex_mode,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_tick
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_MAX     = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] GUARD_START = DW'(SCAN_DIV - BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX     = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] AN_OFF  = ANODE_OFF[DIGITS-1:0];

    logic [DW-1:0]         div;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_off;
    logic [4*DIGITS-1:0]   sh_data;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blank;
    logic [DIGITS-1:0]     sh_blink;
    logic                  sh_hex;

    logic                  div_wrap;
    logic                  frame_start;
    logic                  frame_end;
    logic                  guard;

    logic [4*DIGITS-1:0]   eff_data;
    logic [DIGITS-1:0]     eff_dp;
    logic [DIGITS-1:0]     eff_blank;
    logic [DIGITS-1:0]     eff_blink;
    logic                  eff_hex;

    logic [3:0]            code;
    logic                  dp_sel;
    logic                  blank_sel;
    logic                  blink_sel;
    logic [6:0]            glyph;
    logic                  glyph_ok;
    logic                  dark;
    logic [7:0]            seg_nxt;
    logic [DIGITS-1:0]     an_nxt;

    assign div_wrap    = (div == DIV_MAX);
    assign frame_start = (div == '0) && (idx == '0);
    assign frame_end   = div_wrap && (idx == IDX_MAX);
    assign guard       = (div >= GUARD_START);

    // The frame-start slot sees the values being captured, so a
    // whole frame is drawn from one consistent input snapshot.
    assign eff_data  = frame_start ? digit_data : sh_data;
    assign eff_dp    = frame_start ? dp_in      : sh_dp;
    assign eff_blank = frame_start ? blank_mask : sh_blank;
    assign eff_blink = frame_start ? blink_mask : sh_blink;
    assign eff_hex   = frame_start ? hex_mode   : sh_hex;

    always_comb begin
        code      = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        blink_sel = 1'b0;
        an_nxt    = AN_OFF;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                code      = eff_data[4*i +: 4];
                dp_sel    = eff_dp[i];
                blank_sel = eff_blank[i];
                blink_sel = eff_blink[i];
                an_nxt[i] = 1'b0;
            end
        end
        if (guard) begin
            an_nxt = AN_OFF;
        end
    end

    seg_glyph u_glyph (
        .code     (code),
        .hex_mode (eff_hex),
        .pattern  (glyph),
        .valid    (glyph_ok)
    );

    assign dark = blank_sel || (blink_sel && blink_off) || !glyph_ok;

    always_comb begin
        seg_nxt = {~dp_sel, glyph};
        if (guard || dark) begin
            seg_nxt = SEG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            idx        <= '0;
            blink_cnt  <= '0;
            blink_off  <= 1'b0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_blink   <= '0;
            sh_hex     <= 1'b0;
            frame_tick <= 1'b0;
            seg_out    <= SEG_OFF;
            an_out     <= AN_OFF;
        end else begin
            div <= div_wrap ? '0 : div + DW'(1);
            if (div_wrap) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end
            if (frame_start) begin
                sh_data  <= digit_data;
                sh_dp    <= dp_in;
                sh_blank <= blank_mask;
                sh_blink <= blink_mask;
                sh_hex   <= hex_mode;
            end
            if (frame_end) begin
                if (blink_cnt == BLINK_MAX) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
            frame_tick <= frame_start;
            seg_out    <= seg_nxt;
            an_out     <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan against a cycle-position
// reference model (4 digits, 8-cycle slots, 2-frame blink).
module tb_seg_scan;

    localparam int D     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = D * SD;

    localparam logic [6:0] GT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  digit_data;
    logic [3:0]   dp_in;
    logic [3:0]   blank_mask;
    logic [3:0]   blink_mask;
    logic         hex_mode;
    logic [7:0]   seg_out;
    logic [3:0]   an_out;
    logic         frame_tick;

    int compared   = 0;
    int mismatched = 0;
    int unsigned k = 0;

    logic [15:0] s_data;
    logic [3:0]  s_dp;
    logic [3:0]  s_blank;
    logic [3:0]  s_blink;
    logic        s_hex;

    seg_scan #(
        .DIGITS       (D),
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .hex_mode   (hex_mode),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s k=%0d: observed %h expected %h",
                   tag, k, obs, exp);
        end
    endtask

    // Expected outputs after the edge numbered kk since reset release.
    task automatic model(input int unsigned kk, output logic [7:0] es,
                         output logic [3:0] ea, output logic et);
        int unsigned pos, d, sub, f;
        logic [3:0] c;
        logic off, dk;
        pos = kk % FRAME;
        d   = pos / SD;
        sub = pos % SD;
        f   = kk / FRAME;
        et  = (pos == 0);
        if (sub >= SD - BC) begin
            es = 8'hFF;
            ea = 4'hF;
        end else begin
            ea  = 4'hF & ~(4'b0001 << d);
            c   = 4'((s_data >> (4 * d)) & 16'hF);
            off = ((f / BF) % 2) == 1;
            dk  = s_blank[d] || (s_blink[d] && off) || (c >= 4'hA && !s_hex);
            es  = dk ? 8'hFF : {~s_dp[d], GT[c]};
        end
    endtask

    task automatic step();
        logic [7:0] es;
        logic [3:0] ea;
        logic et;
        int unsigned kk;
        @(posedge clk);
        if (k % FRAME == 0) begin
            s_data  = digit_data;
            s_dp    = dp_in;
            s_blank = blank_mask;
            s_blink = blink_mask;
            s_hex   = hex_mode;
        end
        kk = k;
        k  = k + 1;
        #1;
        model(kk, es, ea, et);
        check("seg_out", seg_out, es);
        check("an_out", {4'h0, an_out}, {4'h0, ea});
        check("frame_tick", {7'h0, frame_tick}, {7'h0, et});
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    initial begin
        rst_n      = 1'b0;
        digit_data = 16'h0;
        dp_in      = 4'h0;
        blank_mask = 4'h0;
        blink_mask = 4'h0;
        hex_mode   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", seg_out, 8'hFF);
        check("rst_an", {4'h0, an_out}, 8'h0F);
        check("rst_tick", {7'h0, frame_tick}, 8'h00);

        digit_data = 16'h4321;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        run(2 * FRAME);

        digit_data = 16'hFA00;
        run(FRAME);
        hex_mode = 1'b1;
        run(FRAME);

        hex_mode   = 1'b0;
        digit_data = 16'h4321;
        dp_in      = 4'b0100;
        blank_mask = 4'b0100;
        run(FRAME);
        blank_mask = 4'b0000;
        run(FRAME);

        dp_in      = 4'b0000;
        blink_mask = 4'b0001;
        run(6 * FRAME);

        run(16);
        digit_data = 16'h9876;
        dp_in      = 4'b1010;
        run(16 + FRAME);

        repeat (40) begin
            digit_data = 16'($urandom);
            dp_in      = 4'($urandom);
            blank_mask = 4'($urandom) & 4'($urandom);
            blink_mask = 4'($urandom);
            hex_mode   = 1'($urandom);
            run(int'($urandom_range(1, 40)));
        end

        blank_mask = 4'h0;
        blink_mask = 4'h0;
        hex_mode   = 1'b0;
        digit_data = 16'h5555;
        run(FRAME);
        while (k % FRAME != 19) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", seg_out, 8'hFF);
        check("async_rst_an", {4'h0, an_out}, 8'h0F);
        check("async_rst_tick", {7'h0, frame_tick}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("hold_rst_seg", seg_out, 8'hFF);
        check("hold_rst_an", {4'h0, an_out}, 8'h0F);

        digit_data = 16'h8A27;
        dp_in      = 4'b0001;
        hex_mode   = 1'b1;
        blink_mask = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        run(5 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range >= 4.
REQ-003 Parameter BLANK_CYC, default 500: anode-off guard cycles at the end of each slot; legal range 1..SCAN_DIV-1.
REQ-004 Parameter BLINK_FRAMES, default 125: full scan frames per blink half-period; legal range >= 1.
REQ-005 clk  input  1  system clock, single clock domain.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 digit_data  input  4*DIGITS  nibble per digit; digit i is at [4i+3:4i].
REQ-008 dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
REQ-009 blank_mask  input  DIGITS  1 = digit forced dark.
REQ-010 blink_mask  input  DIGITS  1 = digit dark during the blink-off phase.
REQ-011 hex_mode  input  1  1 = show A-F glyphs; 0 = codes A-F shown dark (legacy decimal behaviour).
REQ-012 seg_out  output  8  active-low segments, bit7 = dp, bit6 = g ... bit0 = a.
REQ-013 an_out  output  DIGITS  active-low anode enables, one-hot-low or all-high.
REQ-014 frame_tick  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-015 Divider div SHALL count 0..SCAN_DIV-1 and wrap; digit index idx SHALL advance when div = SCAN_DIV-1, wrapping DIGITS-1 -> 0.
REQ-016 Frame start is div = 0 and idx = 0; on that cycle digit_data, dp_in, blank_mask, blink_mask and hex_mode SHALL be captured into shadow registers, and all display decisions within the frame SHALL use shadow values only (no tearing).
REQ-017 frame_tick SHALL be registered and high for exactly the one cycle after each frame start.
REQ-018 Blink phase SHALL start visible and toggle after every BLINK_FRAMES completed frames; the frame counter wraps at BLINK_FRAMES-1.
REQ-019 Digit idx is dark when shadow blank_mask[idx] = 1, or blink_mask[idx] = 1 during the off phase, or code >= A with hex_mode = 0; dark means seg_out = 8'hFF with an_out[idx] still driven low.
REQ-020 Glyphs (bits 6..0): 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.
REQ-021 seg_out[7] SHALL be 0 only when shadow dp_in[idx] = 1 and the digit is not dark.
REQ-022 While div >= SCAN_DIV-BLANK_CYC, an_out SHALL be all ones and seg_out 8'hFF (ghost guard).
REQ-023 seg_out and an_out SHALL be registered, reflecting div/idx/shadow state with exactly one cycle of latency.
REQ-024 With DIGITS = 1, idx stays 0 and every slot is a frame start.

Reset
REQ-025 While rst_n = 0: div = 0, idx = 0, blink phase visible, blink frame counter 0, shadows 0, an_out all ones, seg_out 8'hFF, frame_tick 0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately (asynchronously); the first cycle after release is a frame start and captures inputs.

Structure
REQ-027 Package seg_pkg SHALL hold the 16 glyph constants, SEG_OFF = 8'hFF and an ANODE_OFF helper constant.
REQ-028 Glyph lookup SHALL be a combinational sub-module seg_glyph (4-bit code + hex_mode in, 7-bit pattern + valid out); all state lives in seg_scan.

Verification (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-029 digit_data=16'h4321, masks 0 -> an_out walks 1110,1101,1011,0111 each low for 6 cycles then 1111 for 2; seg_out 8'hF9,8'hA4,8'hB0,8'h99 per slot.
REQ-030 digit_data=16'hFA00, hex_mode=0 then 1 -> digits 2,3 dark, then 8'h88 (A) and 8'h8E (F).
REQ-031 dp_in=4'b0100, blank_mask=4'b0100 -> digit 2 seg_out 8'hFF (dp suppressed); clear blank -> bit7 low on digit 2 only.
REQ-032 blink_mask=4'b0001 -> digit 0 lit frames 0-1, dark frames 2-3, lit 4-5; frame_tick every 32 cycles.
REQ-033 Change digit_data at frame mid-point -> displayed values unchanged until after the next frame_tick.
REQ-034 Assert rst_n low at idx=2, div=3 -> outputs 8'hFF/1111 same cycle; after release frame_tick in first cycle after the capture, scan restarts at digit 0.
